// File: rtl/sobel_kernel.sv
`default_nettype none
// ============================================================================
// sobel_kernel : 3x3 column window + 3-stage |Gx|+|Gy| Sobel pipeline.
// Optional macro SOBEL_THRESH_EN turns the output into a binary edge map.
// Revision: 1.0
// ============================================================================
module sobel_kernel #(
    parameter int PIX_W       = 8,
    parameter int WIDTH_SOBEL = 8,
    parameter int THRESH      = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic             sobel_pulse,
    input  logic [PIX_W-1:0] pix_top,
    input  logic [PIX_W-1:0] pix_mid,
    input  logic [PIX_W-1:0] pix_bot,
    output logic             edge_valid,
    output logic [PIX_W-1:0] edge_pix,
    output logic             edge_last,
    output logic             frame_done
);

    localparam int         GW      = PIX_W + 3;
    localparam int         PIX_MAX = (1 << PIX_W) - 1;
    localparam logic [8:0] WIDTH_C = 9'(WIDTH_SOBEL);

    if ((THRESH < 0) || (THRESH > (1 << GW) - 1)) begin : g_thresh_range
        $error("sobel_kernel: THRESH out of range");
    end

    // a + 2b + c, zero-extended into the gradient width
    function automatic logic [GW-1:0] sum3(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b,
                                           input logic [PIX_W-1:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [GW-1:0] abs_s(input logic [GW-1:0] v);
        return v[GW-1] ? (~v + GW'(1)) : v;
    endfunction

    // Window: index 0 is the oldest column, index 2 the newest
    logic [2:0][PIX_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [8:0]            col_cnt_q, col_cnt_d;
    logic [1:0]            line_cnt_q, line_cnt_d;

    logic          v1_q, v1_d, last1_q, last1_d, fd1_q, fd1_d;
    logic [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic          v2_q, v2_d, last2_q, last2_d, fd2_q, fd2_d;
    logic [GW-1:0] mag_q, mag_d;
    logic             edge_valid_q, edge_valid_d, edge_last_q, edge_last_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] edge_pix_q, edge_pix_d;

    logic clr, accept;

    always_comb begin
        top_d      = top_q;
        mid_d      = mid_q;
        bot_d      = bot_q;
        col_cnt_d  = col_cnt_q;
        line_cnt_d = line_cnt_q;
        clr        = frame_start | line_start;
        accept     = sobel_pulse && (clr || (col_cnt_q < WIDTH_C));

        if (clr) begin
            top_d     = '0;
            mid_d     = '0;
            bot_d     = '0;
            col_cnt_d = '0;
            if (frame_start)
                line_cnt_d = 2'd0;
            else if (line_cnt_q != 2'd3)
                line_cnt_d = line_cnt_q + 2'd1;
        end
        if (accept) begin
            top_d     = {pix_top, top_d[2:1]};
            mid_d     = {pix_mid, mid_d[2:1]};
            bot_d     = {pix_bot, bot_d[2:1]};
            col_cnt_d = col_cnt_d + 9'd1;
        end

        // A load coinciding with a clear leaves col_cnt at 1, so it never issues
        v1_d    = accept && (col_cnt_d >= 9'd3);
        last1_d = v1_d && (col_cnt_d == WIDTH_C);
        fd1_d   = last1_d && (line_cnt_q == 2'd3);
        gx_d    = sum3(top_d[2], mid_d[2], bot_d[2]) - sum3(top_d[0], mid_d[0], bot_d[0]);
        gy_d    = sum3(top_d[0], top_d[1], top_d[2]) - sum3(bot_d[0], bot_d[1], bot_d[2]);

        v2_d    = v1_q;
        last2_d = last1_q;
        fd2_d   = fd1_q;
        mag_d   = abs_s(gx_q) + abs_s(gy_q);

        edge_valid_d = v2_q;
        edge_last_d  = v2_q && last2_q;
        frame_done_d = v2_q && fd2_q;
`ifdef SOBEL_THRESH_EN
        edge_pix_d = (mag_q >= GW'(THRESH)) ? {PIX_W{1'b1}} : '0;
`else
        edge_pix_d = (mag_q > GW'(PIX_MAX)) ? {PIX_W{1'b1}} : mag_q[PIX_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            col_cnt_q    <= '0;
            line_cnt_q   <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            fd1_q        <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            v2_q         <= 1'b0;
            last2_q      <= 1'b0;
            fd2_q        <= 1'b0;
            mag_q        <= '0;
            edge_valid_q <= 1'b0;
            edge_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
            edge_pix_q   <= '0;
        end else begin
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            col_cnt_q    <= col_cnt_d;
            line_cnt_q   <= line_cnt_d;
            v1_q         <= v1_d;
            last1_q      <= last1_d;
            fd1_q        <= fd1_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            v2_q         <= v2_d;
            last2_q      <= last2_d;
            fd2_q        <= fd2_d;
            mag_q        <= mag_d;
            edge_valid_q <= edge_valid_d;
            edge_last_q  <= edge_last_d;
            frame_done_q <= frame_done_d;
            edge_pix_q   <= edge_pix_d;
        end
    end

    assign edge_valid = edge_valid_q;
    assign edge_pix   = edge_pix_q;
    assign edge_last  = edge_last_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_kernel.sv
`default_nettype none
// ============================================================================
// tb_sobel_kernel : directed self-checking bench for sobel_kernel (default build).
// Revision: 1.0
// ============================================================================
module tb_sobel_kernel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       line_start = 1'b0;
    logic       sobel_pulse = 1'b0;
    logic [7:0] pix_top = '0;
    logic [7:0] pix_mid = '0;
    logic [7:0] pix_bot = '0;
    logic       edge_valid;
    logic [7:0] edge_pix;
    logic       edge_last;
    logic       frame_done;

    sobel_kernel #(.PIX_W(8), .WIDTH_SOBEL(8), .THRESH(100)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
        .sobel_pulse(sobel_pulse), .pix_top(pix_top), .pix_mid(pix_mid),
        .pix_bot(pix_bot), .edge_valid(edge_valid), .edge_pix(edge_pix),
        .edge_last(edge_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int pix;
        int last;
        int fd;
    } ev_t;

    ev_t log_q[$];
    int  cyc = 0;
    int  fd_cnt = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  drv_cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (edge_valid)
            log_q.push_back('{cyc, int'(edge_pix), int'(edge_last), int'(frame_done)});
        if (frame_done)
            fd_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic col(input int t, input int m, input int b, input bit ls, input bit fs);
        pix_top     = 8'(t);
        pix_mid     = 8'(m);
        pix_bot     = 8'(b);
        sobel_pulse = 1'b1;
        line_start  = ls;
        frame_start = fs;
        drv_cyc     = cyc;
        step();
        sobel_pulse = 1'b0;
        line_start  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic new_line(input bit fs);
        line_start  = ~fs;
        frame_start = fs;
        step();
        line_start  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic clear_log();
        log_q.delete();
        fd_cnt = 0;
    endtask

    function automatic int ev_pix(input int i);
        return (i < log_q.size()) ? log_q[i].pix : -1;
    endfunction
    function automatic int ev_last(input int i);
        return (i < log_q.size()) ? log_q[i].last : -1;
    endfunction
    function automatic int ev_cyc(input int i);
        return (i < log_q.size()) ? log_q[i].cyc : -1;
    endfunction
    function automatic int ev_fd(input int i);
        return (i < log_q.size()) ? log_q[i].fd : -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 8 uniform-128 columns: six zero results, last flag on the sixth only
    task automatic uniform_line(input string tag);
        int p3;
        new_line(1'b0);
        clear_log();
        p3 = 0;
        for (int i = 1; i <= 8; i++) begin
            col(128, 128, 128, 1'b0, 1'b0);
            if (i == 3) p3 = drv_cyc;
        end
        idle(5);
        chk({tag, "_count"}, log_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_pix%0d", tag, i), ev_pix(i), 0);
            chk($sformatf("%s_last%0d", tag, i), ev_last(i), (i == 5) ? 1 : 0);
        end
        chk({tag, "_latency"}, ev_cyc(0), p3 + 3);
    endtask

    initial begin
        int pc;
        idle(2);
        chk("rst_valid", int'(edge_valid), 0);
        chk("rst_pix", int'(edge_pix), 0);
        chk("rst_last", int'(edge_last), 0);
        chk("rst_fdone", int'(frame_done), 0);
        rst = 1'b0;
        idle(1);

        uniform_line("uni");

        // Horizontal ramp: Gx = 4*30 - 4*10 = 80
        new_line(1'b0);
        clear_log();
        col(10, 10, 10, 1'b0, 1'b0);
        col(20, 20, 20, 1'b0, 1'b0);
        col(30, 30, 30, 1'b0, 1'b0);
        idle(4);
        chk("ramp_count", log_q.size(), 1);
        chk("ramp_pix", ev_pix(0), 80);
        chk("ramp_last", ev_last(0), 0);

        // Step 0 -> 255: Gx = 1020, saturates to 255
        new_line(1'b0);
        clear_log();
        col(0, 0, 0, 1'b0, 1'b0);
        col(255, 255, 255, 1'b0, 1'b0);
        col(255, 255, 255, 1'b0, 1'b0);
        idle(4);
        chk("sat_count", log_q.size(), 1);
        chk("sat_pix", ev_pix(0), 255);

        // Vertical edge: Gy = 200, Gx = 0
        new_line(1'b0);
        clear_log();
        for (int i = 0; i < 4; i++) col(50, 50, 0, 1'b0, 1'b0);
        idle(4);
        chk("gy_count", log_q.size(), 2);
        chk("gy_pix0", ev_pix(0), 200);
        chk("gy_pix1", ev_pix(1), 200);

        // line_start with the 5th pulse: earlier results survive, restart needs 3 columns
        new_line(1'b0);
        clear_log();
        col(10, 10, 10, 1'b0, 1'b0);
        col(20, 20, 20, 1'b0, 1'b0);
        col(30, 30, 30, 1'b0, 1'b0);
        col(40, 40, 40, 1'b0, 1'b0);
        col(0, 0, 0, 1'b1, 1'b0);
        col(50, 50, 50, 1'b0, 1'b0);
        col(60, 60, 60, 1'b0, 1'b0);
        pc = drv_cyc;
        idle(4);
        chk("restart_count", log_q.size(), 3);
        chk("restart_pix0", ev_pix(0), 80);
        chk("restart_pix1", ev_pix(1), 80);
        chk("restart_pix2", ev_pix(2), 240);
        chk("restart_cyc2", ev_cyc(2), pc + 3);

        // 10 pulses on an 8-wide line: zero-valued pulses 9 and 10 must be ignored
        new_line(1'b0);
        clear_log();
        for (int i = 0; i < 8; i++) col(128, 128, 128, 1'b0, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        idle(4);
        chk("over_count", log_q.size(), 6);
        chk("over_pix5", ev_pix(5), 0);
        chk("over_last5", ev_last(5), 1);

        // Reset one clock after the 3rd accepted pulse discards the result
        new_line(1'b0);
        clear_log();
        for (int i = 0; i < 3; i++) col(0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        chk("rst_flight_count", log_q.size(), 0);
        uniform_line("post_rst");

        // frame_start then three lines: a single frame_done with the final edge_last
        new_line(1'b1);
        clear_log();
        for (int l = 0; l < 3; l++) begin
            new_line(1'b0);
            for (int i = 0; i < 8; i++) col(100, 100, 100, 1'b0, 1'b0);
            idle(4);
        end
        chk("frame_count", log_q.size(), 18);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_fd_line2", ev_fd(11), 0);
        chk("frame_fd_last", ev_fd(17), 1);
        chk("frame_last_last", ev_last(17), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
